sram_arbiter: RTL and testbench

- Two-port round-robin arbiter sharing the single sram_top request interface (req/ready/rd/addr/be/wr_data, in-order rd_data_vld return) between two requesters, e.g. a test engine and a UART/SPI host bridge.
- Forwards the granted request combinationally and holds the grant until the transfer is accepted.
- Tracks the owner of each outstanding read in a tag FIFO, so returned read data reaches the requester that issued the read.

---
 rtl/sram_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Two-requester round-robin arbiter in front of a single sram_top request
// port. The granted request is forwarded combinationally and the grant is
// held while the downstream side stalls. Each accepted read pushes its
// owner id into a small tag FIFO, so in-order read returns are steered back
// to the requester that issued them.
//
// Ports
//   clk, reset_            system clock, async active-low reset
//   mN_req/rd/addr/be/     requester N request; fields held until mN_ready
//     wr_data
//   mN_ready               requester N transfer accepted this cycle
//   mN_rd_data_vld/data    read return for requester N (data broadcast)
//   sram_req/rd/addr/be/   downstream request, sram_ready accepts it
//     wr_data, sram_ready
//   sram_rd_data_vld/data  downstream in-order read return
//   err_orphan             sticky: a return arrived with no read outstanding
module sram_arbiter #(
  parameter int TAG_DEPTH = 4,
  parameter int AW        = 18,
  parameter int DW        = 16
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          m0_req,
  output logic          m0_ready,
  input  logic          m0_rd,
  input  logic [AW-1:0] m0_addr,
  input  logic [1:0]    m0_be,
  input  logic [DW-1:0] m0_wr_data,
  output logic          m0_rd_data_vld,
  output logic [DW-1:0] m0_rd_data,
  input  logic          m1_req,
  output logic          m1_ready,
  input  logic          m1_rd,
  input  logic [AW-1:0] m1_addr,
  input  logic [1:0]    m1_be,
  input  logic [DW-1:0] m1_wr_data,
  output logic          m1_rd_data_vld,
  output logic [DW-1:0] m1_rd_data,
  output logic          sram_req,
  input  logic          sram_ready,
  output logic          sram_rd,
  output logic [AW-1:0] sram_addr,
  output logic [1:0]    sram_be,
  output logic [DW-1:0] sram_wr_data,
  input  logic          sram_rd_data_vld,
  input  logic [DW-1:0] sram_rd_data,
  output logic          err_orphan
);

  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TAG_DEPTH);

  logic                 lock_q, lock_d;
  logic                 lock_id_q, lock_id_d;
  logic                 last_grant_q, last_grant_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [TAG_DEPTH-1:0] tag_q, tag_d;
  logic                 err_orphan_q, err_orphan_d;

  logic gnt_vld, gnt_id, sel_req, blocked, xfer, push, pop, tags_empty, head;

  // Grant selection. Outputs are forced quiet while reset_ is low, whatever
  // the requesters happen to be driving.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (!reset_) begin
      gnt_vld = 1'b0;
    end else if (lock_q) begin
      gnt_vld = 1'b1;
      gnt_id  = lock_id_q;
    end else if (m0_req && m1_req) begin
      gnt_vld = 1'b1;
      gnt_id  = ~last_grant_q;
    end else if (m0_req) begin
      gnt_vld = 1'b1;
    end else if (m1_req) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b1;
    end
  end

  always_comb begin
    sel_req      = 1'b0;
    sram_rd      = 1'b0;
    sram_addr    = '0;
    sram_be      = '0;
    sram_wr_data = '0;
    if (gnt_vld) begin
      if (gnt_id) begin
        sel_req      = m1_req;
        sram_rd      = m1_rd;
        sram_addr    = m1_addr;
        sram_be      = m1_be;
        sram_wr_data = m1_wr_data;
      end else begin
        sel_req      = m0_req;
        sram_rd      = m0_rd;
        sram_addr    = m0_addr;
        sram_be      = m0_be;
        sram_wr_data = m0_wr_data;
      end
    end
  end

  assign tags_empty = (count_q == '0);
  assign head       = tag_q[rd_ptr_q];

  // A read may not enter with the tag FIFO full, unless a return frees a
  // slot in the same cycle.
  assign blocked  = gnt_vld && sram_rd && (count_q == FULL_CNT) && !sram_rd_data_vld;
  assign sram_req = gnt_vld && sel_req && !blocked;
  assign xfer     = sram_req && sram_ready;
  assign m0_ready = xfer && !gnt_id;
  assign m1_ready = xfer && gnt_id;

  assign push = xfer && sram_rd;
  assign pop  = sram_rd_data_vld && !tags_empty;

  assign m0_rd_data_vld = reset_ && pop && !head;
  assign m1_rd_data_vld = reset_ && pop && head;
  assign m0_rd_data     = {DW{reset_}} & sram_rd_data;
  assign m1_rd_data     = {DW{reset_}} & sram_rd_data;
  assign err_orphan     = err_orphan_q;

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (xfer) begin
      lock_d = 1'b0;
    end else if (sram_req) begin
      lock_d    = 1'b1;
      lock_id_d = gnt_id;
    end

    last_grant_d = xfer ? gnt_id : last_grant_q;

    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      tag_d[wr_ptr_q] = gnt_id;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    err_orphan_d = err_orphan_q | (sram_rd_data_vld && tags_empty && !push);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      lock_q       <= 1'b0;
      lock_id_q    <= 1'b0;
      last_grant_q <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tag_q        <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_id_q    <= lock_id_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tag_q        <= tag_d;
      err_orphan_q <= err_orphan_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
// Drives both requesters and a behavioural SRAM, while a separate monitor
// checks every cycle against a transaction-level reference model (owner
// queue, lock/last-grant bookkeeping) and a per-requester read-data
// scoreboard.
module tb_sram_arbiter;
  localparam int TAG_DEPTH = 4;
  localparam int AW = 18;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset_ = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    m_req, m_rd;
  logic [AW-1:0] m_addr [2];
  logic [1:0]    m_be [2];
  logic [DW-1:0] m_wd [2];
  logic          m0_ready, m1_ready, m0_vld, m1_vld;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          s_req, s_ready, s_rd, s_vld, err_orphan;
  logic [AW-1:0] s_addr;
  logic [1:0]    s_be;
  logic [DW-1:0] s_wd, s_rdata;

  sram_arbiter #(.TAG_DEPTH(TAG_DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_(reset_),
    .m0_req(m_req[0]), .m0_ready(m0_ready), .m0_rd(m_rd[0]), .m0_addr(m_addr[0]),
    .m0_be(m_be[0]), .m0_wr_data(m_wd[0]), .m0_rd_data_vld(m0_vld), .m0_rd_data(m0_rdata),
    .m1_req(m_req[1]), .m1_ready(m1_ready), .m1_rd(m_rd[1]), .m1_addr(m_addr[1]),
    .m1_be(m_be[1]), .m1_wr_data(m_wd[1]), .m1_rd_data_vld(m1_vld), .m1_rd_data(m1_rdata),
    .sram_req(s_req), .sram_ready(s_ready), .sram_rd(s_rd), .sram_addr(s_addr),
    .sram_be(s_be), .sram_wr_data(s_wd), .sram_rd_data_vld(s_vld), .sram_rd_data(s_rdata),
    .err_orphan(err_orphan)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stimulus state
  bit            active [2];
  logic          stg_rd [2];
  logic [AW-1:0] stg_addr [2];
  logic [1:0]    stg_be [2];
  logic [DW-1:0] stg_wd [2];
  int            issue_pct [2];
  int            rd_mode [2];   // 0 random, 1 writes only, 2 reads only
  int            rdy_pct = 100;
  int            ret_pct = 0;
  bit            force_vld = 1'b0;
  logic [AW-1:0] pend [$];
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  int            grant_log [$];
  logic [DW-1:0] mem [int];

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    int k;
    logic [DW-1:0] v;
    k = int'(a);
    if (mem.exists(k)) return mem[k];
    v = DW'(k * 13) ^ 16'h3C5A;
    return v;
  endfunction

  task automatic issue(input int n, input logic rd, input logic [AW-1:0] a);
    active[n]   = 1'b1;
    stg_rd[n]   = rd;
    stg_addr[n] = a;
    stg_be[n]   = 2'($urandom_range(1, 3));
    stg_wd[n]   = DW'($urandom);
  endtask

  // One clock: drive inputs after the rising edge, observe handshakes at the
  // falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      if (!active[n] && int'($urandom_range(99)) < issue_pct[n])
        issue(n, (rd_mode[n] == 0) ? 1'($urandom_range(1)) : (rd_mode[n] == 2),
              AW'($urandom));
      m_req[n]  = active[n];
      m_rd[n]   = stg_rd[n];
      m_addr[n] = stg_addr[n];
      m_be[n]   = stg_be[n];
      m_wd[n]   = stg_wd[n];
    end
    s_ready = (int'($urandom_range(99)) < rdy_pct);
    if (force_vld) begin
      s_vld   = 1'b1;
      s_rdata = DW'($urandom);
    end else if (pend.size() > 0 && int'($urandom_range(99)) < ret_pct) begin
      s_vld   = 1'b1;
      s_rdata = rd_val(pend.pop_front());
    end else begin
      s_vld   = 1'b0;
      s_rdata = DW'($urandom);
    end
    @(negedge clk);
    if (m0_ready) begin
      active[0] = 1'b0;
      grant_log.push_back(0);
      if (stg_rd[0]) exp_q0.push_back(rd_val(stg_addr[0]));
    end
    if (m1_ready) begin
      active[1] = 1'b0;
      grant_log.push_back(1);
      if (stg_rd[1]) exp_q1.push_back(rd_val(stg_addr[1]));
    end
    if (s_req && s_ready && s_rd) pend.push_back(s_addr);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    issue_pct[0] = 0;
    issue_pct[1] = 0;
    rdy_pct = 100;
    ret_pct = 100;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      #1;
      done = !active[0] && !active[1] && pend.size() == 0 &&
             exp_q0.size() == 0 && exp_q1.size() == 0;
    end
    chk("drain_done", done, 1);
    ret_pct = 0;
  endtask

  task automatic do_reset();
    #2;
    s_ready = 1'b1;
    s_vld   = 1'b1;
    s_rdata = 16'hFFFF;
    reset_  = 1'b0;
    #1;
    chk("rst_sram_req", s_req, 0);
    chk("rst_ready", {m0_ready, m1_ready}, 0);
    chk("rst_rd_vld", {m0_vld, m1_vld}, 0);
    chk("rst_rd_data", m0_rdata | m1_rdata, 0);
    chk("rst_sram_addr", s_addr, 0);
    chk("rst_err_orphan", err_orphan, 0);
    for (int n = 0; n < 2; n++) begin
      active[n] = 1'b0;
      issue_pct[n] = 0;
      m_req[n] = 1'b0;
    end
    s_ready = 1'b0;
    s_vld   = 1'b0;
    force_vld = 1'b0;
    pend.delete();
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) @(negedge clk);
    #1 reset_ = 1'b1;
  endtask

  // Monitor: reference model at transaction level.
  int mdl_last = 1;
  bit mdl_lock = 1'b0;
  int mdl_lock_id = 0;
  bit mdl_err = 1'b0;
  int own_q [$];

  initial begin
    int  g, owner;
    bit  gr, blk, exp_sreq, xf, psh;
    forever begin
      @(negedge clk);
      if (!reset_) begin
        chk("reset_outputs", {s_req, m0_ready, m1_ready, m0_vld, m1_vld, err_orphan}, 0);
        mdl_last = 1;
        mdl_lock = 1'b0;
        mdl_err  = 1'b0;
        own_q.delete();
      end else begin
        if (mdl_lock) g = mdl_lock_id;
        else if (m_req[0] && m_req[1]) g = 1 - mdl_last;
        else if (m_req[0]) g = 0;
        else if (m_req[1]) g = 1;
        else g = -1;

        if (g >= 0) begin
          chk("sram_rd", s_rd, m_rd[g]);
          chk("sram_addr", s_addr, m_addr[g]);
          chk("sram_be", s_be, m_be[g]);
          chk("sram_wr_data", s_wd, m_wd[g]);
          gr  = m_req[g];
          blk = m_rd[g] && own_q.size() == TAG_DEPTH && !s_vld;
        end else begin
          chk("idle_mux_zero", s_rd | (|s_be) | (|s_addr) | (|s_wd), 0);
          gr  = 1'b0;
          blk = 1'b0;
        end
        exp_sreq = gr && !blk;
        xf  = exp_sreq && s_ready;
        psh = xf ? m_rd[g] : 1'b0;
        chk("sram_req", s_req, exp_sreq);
        chk("m0_ready", m0_ready, xf && g == 0);
        chk("m1_ready", m1_ready, xf && g == 1);
        chk("err_orphan", err_orphan, mdl_err);
        chk("rd_data_bcast", (m0_rdata == s_rdata) && (m1_rdata == s_rdata), 1);

        owner = -1;
        if (s_vld && own_q.size() > 0) owner = own_q.pop_front();
        else if (s_vld && !psh) mdl_err = 1'b1;
        chk("m0_rd_data_vld", m0_vld, owner == 0);
        chk("m1_rd_data_vld", m1_vld, owner == 1);

        if (m0_vld) begin
          if (exp_q0.size() == 0) chk("m0_unexpected_return", 1, 0);
          else chk("m0_rd_data", m0_rdata, exp_q0.pop_front());
        end
        if (m1_vld) begin
          if (exp_q1.size() == 0) chk("m1_unexpected_return", 1, 0);
          else chk("m1_rd_data", m1_rdata, exp_q1.pop_front());
        end

        if (xf) begin
          mdl_last = g;
          mdl_lock = 1'b0;
          if (psh) own_q.push_back(g);
        end else if (exp_sreq) begin
          mdl_lock = 1'b1;
          mdl_lock_id = g;
        end
      end
    end
  end

  initial begin
    int acc;
    bit ok;
    for (int n = 0; n < 2; n++) begin
      active[n] = 1'b0; stg_rd[n] = 1'b0; stg_addr[n] = '0; stg_be[n] = '0;
      stg_wd[n] = '0; issue_pct[n] = 0; rd_mode[n] = 0;
      m_addr[n] = '0; m_be[n] = '0; m_wd[n] = '0;
    end
    m_req = '0; m_rd = '0;
    s_ready = 1'b0; s_vld = 1'b0; s_rdata = '0;
    repeat (2) @(negedge clk);
    #1 reset_ = 1'b1;

    // Both requesters continuously writing: grants alternate, m0 first.
    rd_mode[0] = 1; rd_mode[1] = 1;
    issue_pct[0] = 100; issue_pct[1] = 100;
    rdy_pct = 100;
    grant_log.delete();
    repeat (8) step();
    chk("alt_count", grant_log.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < grant_log.size()) chk($sformatf("alt_grant%0d", i), grant_log[i], i % 2);
    drain();

    // Stalled m0 write keeps the grant while m1 waits.
    rdy_pct = 0;
    issue(0, 1'b0, 18'h00010);
    step();
    chk("stall_sram_req", s_req, 1);
    chk("stall_addr0", s_addr, 18'h00010);
    issue(1, 1'b0, 18'h00020);
    repeat (2) begin
      step();
      chk("stall_addr_hold", s_addr, 18'h00010);
      chk("stall_m1_ready", m1_ready, 0);
    end
    rdy_pct = 100;
    step();
    chk("stall_m0_accept", m0_ready, 1);
    chk("stall_m0_addr", s_addr, 18'h00010);
    step();
    chk("stall_m1_accept", m1_ready, 1);
    chk("stall_m1_addr", s_addr, 18'h00020);
    drain();

    // Read returns are steered to their issuers.
    mem[5] = 16'hAAAA;
    mem[6] = 16'h5555;
    issue(0, 1'b1, 18'h00005);
    step();
    chk("rd_m0_accept", m0_ready, 1);
    issue(1, 1'b1, 18'h00006);
    step();
    chk("rd_m1_accept", m1_ready, 1);
    ret_pct = 100;
    step();
    chk("ret0_m0_vld", {m0_vld, m1_vld}, 2'b10);
    chk("ret0_data", m0_rdata, 16'hAAAA);
    step();
    chk("ret1_m1_vld", {m0_vld, m1_vld}, 2'b01);
    chk("ret1_data", m1_rdata, 16'h5555);
    drain();

    // Tag FIFO full: the 5th read waits for a return.
    rd_mode[0] = 2;
    issue_pct[0] = 100;
    acc = 0;
    repeat (6) begin
      step();
      acc += int'(m0_ready);
    end
    chk("full_accepts", acc, TAG_DEPTH);
    chk("full_sram_req", s_req, 0);
    issue_pct[0] = 0;
    ret_pct = 100;
    step();
    chk("full_pop_push_ready", m0_ready, 1);
    chk("full_pop_push_vld", m0_vld, 1);
    rd_mode[0] = 0;
    drain();

    // Orphan return.
    force_vld = 1'b1;
    step();
    force_vld = 1'b0;
    chk("orphan_no_vld", {m0_vld, m1_vld}, 0);
    chk("orphan_not_yet", err_orphan, 0);
    step();
    chk("orphan_set", err_orphan, 1);
    repeat (3) step();
    chk("orphan_sticky", err_orphan, 1);

    // Reset with reads outstanding and a request stalled downstream.
    issue(0, 1'b1, 18'h00007);
    issue(1, 1'b1, 18'h00008);
    ok = 1'b0;
    for (int i = 0; i < 6 && !ok; i++) begin
      step();
      ok = !active[0] && !active[1];
    end
    chk("pre_rst_reads_accepted", ok, 1);
    rdy_pct = 0;
    issue(0, 1'b0, 18'h00009);
    issue(1, 1'b0, 18'h0000A);
    step();
    do_reset();
    rdy_pct = 100;
    issue(0, 1'b0, 18'h00001);
    issue(1, 1'b0, 18'h00002);
    step();
    chk("post_rst_grant_m0", m0_ready, 1);
    force_vld = 1'b1;
    step();
    force_vld = 1'b0;
    chk("post_rst_fifo_empty", {m0_vld, m1_vld}, 0);
    step();
    chk("post_rst_orphan", err_orphan, 1);
    drain();

    // Randomized traffic.
    do_reset();
    for (int blk = 0; blk < 20; blk++) begin
      issue_pct[0] = int'($urandom_range(20, 100));
      issue_pct[1] = int'($urandom_range(20, 100));
      rdy_pct = int'($urandom_range(30, 100));
      ret_pct = int'($urandom_range(20, 100));
      repeat (100) step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
